// File: rtl/ras_stack_param.sv
// Return-address stack for the branch predictor.
// A circular buffer of {valid, data} entries with a top pointer and an occupancy count.
// Calls push the return PC and returns pop it. The current pointer, count and top data
// can be captured as a checkpoint. Restoring that checkpoint rewinds the stack after a
// misprediction or a flush.

module ras_stack_param #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OVF_MODE = 0,
  parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop_valid,
  output logic              top_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [PTR_W:0]    ckpt_cnt,
  input  logic              recover_valid,
  input  logic [PTR_W-1:0]  recover_ptr,
  input  logic [PTR_W:0]    recover_cnt,
  input  logic [ADDR_W-1:0] recover_top,
  output logic              ovf_drop
);

  localparam int unsigned CntW = PTR_W + 1;
  localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  // Architectural state
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] data_q [DEPTH];
  logic              ovf_q, ovf_d;

  // Single entry write port shared by push, push+pop replace and recover
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;

  logic is_empty;
  logic is_full;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CntFull);

  // Next-state decode: recover wins over push/pop; push+pop on a non-empty stack replaces top
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = push_addr;

    if (recover_valid) begin
      ptr_d = recover_ptr;
      cnt_d = recover_cnt;
      // An empty checkpoint carries no meaningful top data, so leave storage alone
      if (recover_cnt != '0) begin
        wr_en   = 1'b1;
        wr_idx  = recover_ptr;
        wr_data = recover_top;
      end
    end else if (push_valid && pop_valid && !is_empty) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (push_valid) begin
      // Also covers push+pop on an empty stack, which acts as a plain push
      if (!is_full) begin
        ptr_d  = ptr_q + PtrOne;
        cnt_d  = cnt_q + CntOne;
        wr_en  = 1'b1;
        wr_idx = ptr_q + PtrOne;
      end else if (OVF_MODE == 0) begin
        // Full in wrap mode: advancing the pointer lands on the oldest entry
        ptr_d  = ptr_q + PtrOne;
        wr_en  = 1'b1;
        wr_idx = ptr_q + PtrOne;
        ovf_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop_valid && !is_empty) begin
      // Entry contents are kept so a later recover can re-expose them
      ptr_d = ptr_q - PtrOne;
      cnt_d = cnt_q - CntOne;
    end
  end

  // Pointer, count and overflow pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      data_q[wr_idx]  <= wr_data;
    end
  end

  // Zero-cycle read of the current top and checkpoint fields
  always_comb begin
    top_valid = !is_empty;
    top_addr  = '0;
    if (!is_empty && valid_q[ptr_q]) begin
      top_addr = data_q[ptr_q];
    end
    ckpt_ptr = ptr_q;
    ckpt_cnt = cnt_q;
    ovf_drop = ovf_q;
  end

  // A checkpoint can never hold more entries than the stack has
  a_recover_cnt_legal : assert property (
    @(posedge clk) disable iff (reset) recover_valid |-> (recover_cnt <= CntFull)
  );

  // Overflow reports only come from a push at full occupancy, never from a recovery
  a_ovf_source : assert property (
    @(posedge clk) disable iff (reset) ovf_d |-> (push_valid && !recover_valid && is_full)
  );

endmodule
